// File: rtl/pair_sum_pkg.sv
// Shared sizing for the pair-sum datapath: input word width, memory depths and
// the pointer and sum widths derived from them.
package pair_sum_pkg;
  localparam int DATA_W  = 8;
  localparam int DEPTH_A = 8;
  localparam int DEPTH_B = DEPTH_A / 2;
  localparam int AW_A    = $clog2(DEPTH_A);
  localparam int AW_B    = AW_A - 1;
  localparam int SUM_W   = DATA_W + 1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SUM_W-1:0]  sum_t;
endpackage

// File: rtl/wrap_counter.sv
// Free-running pointer that advances on inc and wraps naturally at 2**WIDTH.
module wrap_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (inc)
      count_reg <= count_reg + 1'b1;
  end

  assign q = count_reg;
endmodule

// File: rtl/pair_sum_datapath.sv
// Captures words into memory A, sums consecutive A pairs into memory B under
// controller strobes, and exposes B through a registered read port.
module pair_sum_datapath
  import pair_sum_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              weA,
  input  logic              incA,
  input  logic              weB,
  input  logic              incB,
  input  logic [DATA_W-1:0] din,
  input  logic [AW_B-1:0]   rd_addr,
  output logic [SUM_W-1:0]  dout,
  output logic [AW_A-1:0]   addr_a,
  output logic [AW_B-1:0]   addr_b,
  output logic              done,
  output logic              ovf
);
  word_t              mem_a_reg [DEPTH_A];
  sum_t               mem_b_reg [DEPTH_B];
  logic [DEPTH_A-1:0] wr_a_sel;
  logic [DEPTH_B-1:0] wr_b_sel;
  word_t              pair_lo;
  word_t              pair_hi;
  sum_t               sum_reg;
  sum_t               sum_next;
  sum_t               dout_reg;
  logic               done_reg;
  logic               ovf_reg;

  wrap_counter #(.WIDTH(AW_A)) u_addr_a (
    .clock (clock),
    .reset (reset),
    .inc   (incA),
    .q     (addr_a)
  );

  wrap_counter #(.WIDTH(AW_B)) u_addr_b (
    .clock (clock),
    .reset (reset),
    .inc   (incB),
    .q     (addr_b)
  );

  generate
    for (genvar gi = 0; gi < DEPTH_A; gi++) begin : g_sel_a
      assign wr_a_sel[gi] = weA && (addr_a == AW_A'(gi));
    end
    for (genvar gi = 0; gi < DEPTH_B; gi++) begin : g_sel_b
      assign wr_b_sel[gi] = weB && (addr_b == AW_B'(gi));
    end
  endgenerate

  // Memories must clear on reset, so they are plain registers rather than RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_A; i++) mem_a_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH_A; i++)
        if (wr_a_sel[i]) mem_a_reg[i] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_B; i++) mem_b_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH_B; i++)
        if (wr_b_sel[i]) mem_b_reg[i] <= sum_reg;
    end
  end

  assign pair_lo  = mem_a_reg[{addr_b, 1'b0}];
  assign pair_hi  = mem_a_reg[{addr_b, 1'b1}];
  assign sum_next = SUM_W'(pair_lo) + SUM_W'(pair_hi);

  // A new A word or B pointer shows up in sum_reg one edge later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_reg  <= '0;
      dout_reg <= '0;
    end else begin
      sum_reg  <= sum_next;
      dout_reg <= mem_b_reg[rd_addr];
    end
  end

  // A new capture (weA) clears both flags and wins over a same-edge set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (weA) begin
      done_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (weB) begin
      if (addr_b == AW_B'(DEPTH_B - 1)) done_reg <= 1'b1;
      if (sum_reg[DATA_W])              ovf_reg  <= 1'b1;
    end
  end

  assign dout = dout_reg;
  assign done = done_reg;
  assign ovf  = ovf_reg;
endmodule
